// File: rtl/rx_byte_fifo_pkg.sv
// Shared parameters and types for the receive byte FIFO that paces bytes
// from the UART/SPI receive path into control_module.
package rx_byte_fifo_pkg;

  localparam int RX_FIFO_DEPTH         = 16;
  localparam int RX_FIFO_MIN_GAP_TICKS = 2;
  localparam int RX_FIFO_GAP_W         = 8;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_GAP  = 1'b1
  } rx_fifo_state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Byte FIFO between the receive path and control_module: stores bytes in order
// and emits them as one-cycle strobes separated by at least MIN_GAP_TICKS idle cycles.
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH         = RX_FIFO_DEPTH,
  parameter int MIN_GAP_TICKS = RX_FIFO_MIN_GAP_TICKS
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  input  logic                     consumer_busy,
  input  logic                     clear_overflow,
  output logic [7:0]               rd_data,
  output logic                     rd_pulse,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]              PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]              PTR_ONE   = AW'(1);
  localparam logic [AW:0]                CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]                CNT_ONE   = (AW + 1)'(1);
  localparam logic [RX_FIFO_GAP_W-1:0]   GAP_INIT  = RX_FIFO_GAP_W'(MIN_GAP_TICKS);
  localparam logic [RX_FIFO_GAP_W-1:0]   GAP_ONE   = RX_FIFO_GAP_W'(1);

  logic [7:0]               mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic                     ovf_q, ovf_d;
  rx_fifo_state_t           state_q, state_d;
  logic [RX_FIFO_GAP_W-1:0] gap_q, gap_d;
  logic [7:0]               rd_data_q, rd_data_d;
  logic                     rd_pulse_q, rd_pulse_d;
  logic                     pop_s, push_s, drop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
  endfunction

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign fill_level = count_q;
  assign overflow   = ovf_q;
  assign rd_data    = rd_data_q;
  assign rd_pulse   = rd_pulse_q;

  // Read FSM state register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Read FSM next state: the gap counter returns to IDLE as it reaches zero.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      RX_IDLE: begin
        if (pop_s) begin
          state_d = RX_GAP;
          gap_d   = GAP_INIT;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_GAP: begin
        if (gap_q <= GAP_ONE) begin
          state_d = RX_IDLE;
          gap_d   = '0;
        end else begin
          gap_d   = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = RX_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Read FSM outputs: pop decision and the registered strobe/data.
  always_comb begin
    pop_s      = 1'b0;
    rd_pulse_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      RX_IDLE: begin
        if (!empty && !consumer_busy) begin
          pop_s      = 1'b1;
          rd_pulse_d = 1'b1;
          rd_data_d  = mem_q[rd_ptr_q];
        end else begin
          pop_s      = 1'b0;
        end
      end
      RX_GAP:  pop_s = 1'b0;
      default: pop_s = 1'b0;
    endcase
  end

  // Write acceptance, pointer/count update and sticky overflow (set beats clear).
  always_comb begin
    push_s   = wr_valid && (!full || pop_s);
    drop_s   = wr_valid && full && !pop_s;
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pointer, fill count, overflow and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  // Byte storage; contents are don't-care after reset since the pointers are cleared.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Randomized scoreboard bench for rx_byte_fifo with a queue-based reference model.
module tb_rx_byte_fifo;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       consumer_busy = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] rd_data;
  logic       rd_pulse;
  logic [$clog2(DEPTH):0] fill_level;
  logic       empty, full, overflow;

  rx_byte_fifo #(.DEPTH(DEPTH), .MIN_GAP_TICKS(GAP)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .consumer_busy(consumer_busy), .clear_overflow(clear_overflow),
    .rd_data(rd_data), .rd_pulse(rd_pulse), .fill_level(fill_level),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] mdl_q [$];
  logic [7:0] exp_q [$];
  int         edge_n = 0;
  int         last_pop = -100;
  bit         mdl_ovf = 1'b0;
  bit         exp_pulse = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] mon_byte;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // Reference: a byte pops when stored, consumer free, and GAP idle cycles have passed.
  task automatic model_edge(input bit v, input logic [7:0] d, input bit busy, input bit clr);
    int sz;
    bit pop, drop;
    sz   = mdl_q.size();
    pop  = (sz > 0) && !busy && (edge_n - last_pop >= GAP + 1);
    drop = v && (sz == DEPTH) && !pop;
    if (pop) begin
      last_byte = mdl_q.pop_front();
      exp_q.push_back(last_byte);
      last_pop = edge_n;
    end
    if (v && !drop) mdl_q.push_back(d);
    if (drop) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    exp_pulse = pop;
    edge_n++;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit busy, input bit clr);
    wr_valid = v; wr_data = d; consumer_busy = busy; clear_overflow = clr;
    @(posedge clk_in);
    model_edge(v, d, busy, clr);
    #1;
    check("fill_level", fill_level, mdl_q.size());
    check("empty", empty, mdl_q.size() == 0);
    check("full", full, mdl_q.size() == DEPTH);
    check("overflow", overflow, mdl_ovf);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, busy, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    #2;
    reset_n = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hEE; consumer_busy = 1'b0; clear_overflow = 1'b0;
    mdl_q.delete(); exp_q.delete();
    mdl_ovf = 1'b0; exp_pulse = 1'b0; last_byte = 8'h00; last_pop = -100;
    #1;
    check("rst_rd_pulse", rd_pulse, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_fill", fill_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_data", rd_data, 0);
    repeat (cycles) @(negedge clk_in);
    reset_n = 1'b1;
    wr_valid = 1'b0;
  endtask

  // Monitor: strobe timing, popped data order and rd_data hold between pops.
  initial begin
    forever begin
      @(negedge clk_in);
      if (reset_n) begin
        check("rd_pulse", rd_pulse, exp_pulse);
        if (rd_pulse) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_data: unexpected byte %0h with empty scoreboard", rd_data);
          end else begin
            mon_byte = exp_q.pop_front();
            check("rd_data", rd_data, mon_byte);
          end
        end else begin
          check("rd_data_hold", rd_data, last_byte);
        end
      end
    end
  end

  initial begin
    @(negedge clk_in);
    do_reset(2);
    // Single byte latency.
    step(1'b1, 8'h62, 1'b0, 1'b0);
    idle(6, 1'b0);
    // Burst pacing.
    step(1'b1, 8'h72, 1'b0, 1'b0);
    step(1'b1, 8'h52, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(10, 1'b0);
    // Backpressure to full, then drain.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
    idle(3, 1'b1);
    idle(16, 1'b0);
    // Overflow and clear.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(16, 1'b0);
    // Simultaneous write and pop while full, across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
    step(1'b1, 8'hC4, 1'b0, 1'b0);
    idle(16, 1'b0);
    // Reset mid-burst.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hD0 + 8'(i), 1'b1, 1'b0);
    do_reset(2);
    step(1'b1, 8'h4C, 1'b0, 1'b0);
    idle(6, 1'b0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0);
    end
    idle(30, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("model_drained", mdl_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
